// File: rtl/exe_mem_stage_reg.sv
// EXE->MEM elastic stage register: valid/ready handshake, 2-entry skid buffer, flush, bubble-gated controls.
// Optional stall/bubble performance counters are enabled with `define EXE_MEM_PERF_CNT_EN.
module exe_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ewreg,
  input  logic              em2reg,
  input  logic              ewmem,
  input  logic              ebranch,
  input  logic              ezero,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] edata_b,
  input  logic [REG_W-1:0]  erdrt,
  input  logic [PC_W-1:0]   epc,
  input  logic [TAG_W-1:0]  EXE_ins_type,
  input  logic [TAG_W-1:0]  EXE_ins_number,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic              mbranch,
  output logic              mzero,
  output logic [DATA_W-1:0] maluout,
  output logic [DATA_W-1:0] mdata_b,
  output logic [REG_W-1:0]  mrdrt,
  output logic [PC_W-1:0]   mpc,
  output logic [TAG_W-1:0]  MEM_ins_type,
  output logic [TAG_W-1:0]  MEM_ins_number
`ifdef EXE_MEM_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              branch;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data_b;
    logic [REG_W-1:0]  rdrt;
    logic [PC_W-1:0]   pc;
    logic [TAG_W-1:0]  itype;
    logic [TAG_W-1:0]  inum;
  } payload_t;

  payload_t r_main;
  payload_t r_skid;
  logic     r_main_v;
  logic     r_skid_v;
  payload_t w_in;
  logic     w_accept;
  logic     w_pop;

  always_comb begin
    w_in        = '0;
    w_in.wreg   = ewreg;
    w_in.m2reg  = em2reg;
    w_in.wmem   = ewmem;
    w_in.branch = ebranch;
    w_in.zero   = ezero;
    w_in.alu    = aluout;
    w_in.data_b = edata_b;
    w_in.rdrt   = erdrt;
    w_in.pc     = epc;
    w_in.itype  = EXE_ins_type;
    w_in.inum   = EXE_ins_number;
  end

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = ~r_skid_v;
  assign w_accept = in_valid & ~r_skid_v;
  assign w_pop    = r_main_v & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_pop && r_skid_v) begin
      r_main   <= r_skid;
      r_skid_v <= 1'b0;
    end else if (w_accept && (!r_main_v || w_pop)) begin
      r_main   <= w_in;
      r_main_v <= 1'b1;
    end else if (w_accept) begin
      r_skid   <= w_in;
      r_skid_v <= 1'b1;
    end else if (w_pop) begin
      r_main_v <= 1'b0;
    end
  end

  // Side-effecting controls are masked so a bubble can never write or branch.
  assign out_valid      = r_main_v;
  assign mwreg          = r_main.wreg   & r_main_v;
  assign mm2reg         = r_main.m2reg  & r_main_v;
  assign mwmem          = r_main.wmem   & r_main_v;
  assign mbranch        = r_main.branch & r_main_v;
  assign mzero          = r_main.zero;
  assign maluout        = r_main.alu;
  assign mdata_b        = r_main.data_b;
  assign mrdrt          = r_main.rdrt;
  assign mpc            = r_main.pc;
  assign MEM_ins_type   = r_main.itype;
  assign MEM_ins_number = r_main.inum;

`ifdef EXE_MEM_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  // Counters survive flush so squash events do not hide stall history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_main_v && !out_ready && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (!r_main_v && r_bubble_cnt != 16'hFFFF)
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: doc/exe_mem_stage_reg.md
Name: exe_mem_stage_reg

Overview:
- Parametrised successor to the fixed EXE/MEM pipeline latch: an elastic EXE->MEM stage register with valid/ready handshake, 2-entry skid buffer, synchronous flush and bubble-safe control outputs.
- Sits between the ALU/branch-compare logic and the data-memory stage.
- Lets MEM stall (e.g. a slow data memory) without losing EXE results.
- Lets hazard/branch logic squash in-flight instructions.

Parameters:
- DATA_W, 32, width of aluout/edata_b paths
- PC_W, 32, width of the pc field
- REG_W, 5, destination register index width
- TAG_W, 4, width of each debug tag (ins_type, ins_number)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  EXE presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- ewreg, em2reg, ewmem, ebranch, ezero  in  1 each  EXE control/status bits
- aluout, edata_b  in  DATA_W each  ALU result, store data
- erdrt  in  REG_W  destination register
- epc  in  PC_W  branch target / pc
- EXE_ins_type, EXE_ins_number  in  TAG_W each  debug tags
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes entry this cycle
- mwreg, mm2reg, mwmem, mbranch, mzero  out  1 each  held control bits
- maluout, mdata_b  out  DATA_W  held data
- mrdrt  out  REG_W
- mpc  out  PC_W
- MEM_ins_type, MEM_ins_number  out  TAG_W
- stall_cnt, bubble_cnt  out  16 each  only with EXE_MEM_PERF_CNT_EN

Behaviour:
- Storage: main entry (drives outputs) plus skid entry; each has a valid bit (main_v, skid_v).
- out_valid = main_v.
- in_ready = ~skid_v, registered; no combinational path from out_ready to in_ready.
- Accept = in_valid & in_ready.
- Pop = main_v & out_ready.
- Per rising edge, priority order:
  1. rst: main_v=skid_v=0; all stored fields=0. Reset values: out_valid=0, in_ready=1, all outputs 0, counters 0.
  2. flush: main_v=skid_v=0; any same-cycle accept is dropped. Data fields may keep stale values; in_ready=1 next cycle.
  3. Otherwise:
     - main empty, or pop with skid empty: accepted input loads main.
     - pop with skid_v=1: skid moves to main; accepted input (impossible, in_ready=0) does not occur.
     - main_v=1, no pop, accept: input loads skid, skid_v=1.
     - pop, no accept, skid empty: main_v=0.
- Latency: 1 cycle from accept to out_valid when the stage is empty and unstalled. Full throughput of 1 instr/cycle with out_ready held high.
- Ordering strictly FIFO; depth 2 max.
- Control safety: mwreg, mwmem, mbranch, mm2reg are ANDed with out_valid, so a bubble never writes the regfile/memory or branches. Data outputs are not gated.
- mzero is passed through ungated; a consumer uses it only with mbranch.
- Fields are transported bit-exact; no width conversion.
- Simultaneous flush & pop: flush wins, the entry is treated as consumed/killed, and no duplicate appears.
- rst asserted mid-stall clears everything identically to power-up.

Optional Feature:
- Macro EXE_MEM_PERF_CNT_EN.
- Defined: adds stall_cnt and bubble_cnt ports.
  - stall_cnt increments each cycle out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle out_valid=0.
  - Both are 16-bit, saturate at 0xFFFF, and clear on rst only (not flush).
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then stream: rst 1 cycle; in_valid=1, out_ready=1, aluout=0x00000010,0x20,0x30 on consecutive cycles -> out_valid rises 1 cycle later; maluout shows 0x10,0x20,0x30 in order, back-to-back; in_ready stays 1.
- Stall/skid: main holds A (aluout=0xA), out_ready=0, present B (0xB) -> B accepted into skid; in_ready=0 next cycle; C held off. Raise out_ready -> A, then B, then C delivered; none lost or duplicated.
- Flush with bubble safety: main=A with ewmem=1, skid=B, flush=1 while in_valid=1 (C) -> next cycle out_valid=0, mwmem=0, mwreg=0, in_ready=1; C not delivered.
- Flush/pop collision: out_ready=1 and flush=1 on the same edge with main=A -> A is not presented again; out_valid=0.
- Reset mid-stall: two entries held, assert rst -> all outputs 0, out_valid=0, in_ready=1 next cycle.
- With EXE_MEM_PERF_CNT_EN: 5 stalled cycles, then 3 empty cycles -> stall_cnt=5, bubble_cnt=3 (+ post-reset idle cycles). Force 70000 stalls -> stall_cnt=0xFFFF.
